// File: rtl/multiplier_datapath_taint_word.sv
// Datapath for the sequential shift-add multiplier with word-level taint.
// Holds the multiplicand (md), the multiplier (mr) and the 2*WIDTH result
// register (rs) plus a carry bit. Each register has a single taint bit
// that follows the strobes issued by the multiplier control FSM.
module multiplier_datapath_taint_word #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     multiplicandIn,
    input  logic                 multiplicandIn_t,
    input  logic [WIDTH-1:0]     multiplierIn,
    input  logic                 multiplierIn_t,
    input  logic                 mdld,
    input  logic                 mdld_t,
    input  logic                 mrld,
    input  logic                 mrld_t,
    input  logic                 rsclear,
    input  logic                 rsclear_t,
    input  logic                 rsload,
    input  logic                 rsload_t,
    input  logic                 rsshr,
    input  logic                 rsshr_t,
    output logic [WIDTH-1:0]     multiplierReg,
    output logic                 multiplierReg_t,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_t
);

    logic [WIDTH-1:0]   md;
    logic [WIDTH-1:0]   mr;
    logic [2*WIDTH-1:0] rs;
    logic               carry;
    logic               md_t;
    logic               mr_t;
    logic               rs_t;

    logic [WIDTH:0]     sum;
    logic               md_t_next;
    logic               mr_t_next;
    logic               rs_t_next;

    // Upper-half add and next-state taint. A tainted strobe taints its
    // destination even when the strobe itself is low; the rs add taint uses
    // the old md_t, matching the add, which uses the old md.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        sum       = {1'b0, rs[2*WIDTH-1:WIDTH]} + {1'b0, md};
        md_t_next = (mdld ? multiplicandIn_t : md_t) | mdld_t;
        mr_t_next = (mrld ? multiplierIn_t : mr_t) | mrld_t;
        rs_t_next = (rsclear ? 1'b0 : rs_t)
                  | (rsclear_t & rs_t)
                  | rsclear_t
                  | rsload_t
                  | rsshr_t
                  | ((rsload | rsload_t) & md_t);
    end

    // Register update: synchronous reset wins over every strobe, then the
    // operand loads and the rs strobes in priority clear > load > shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            md    <= '0;
            mr    <= '0;
            rs    <= '0;
            carry <= 1'b0;
            md_t  <= 1'b0;
            mr_t  <= 1'b0;
            rs_t  <= 1'b0;
        end else begin
            if (mdld) begin
                md <= multiplicandIn;
            end
            if (mrld) begin
                mr <= multiplierIn;
            end
            if (rsclear) begin
                rs    <= '0;
                carry <= 1'b0;
            end else if (rsload) begin
                // Carry lands in its own bit and is folded in by the next shift.
                {carry, rs[2*WIDTH-1:WIDTH]} <= sum;
            end else if (rsshr) begin
                rs    <= {carry, rs[2*WIDTH-1:1]};
                carry <= 1'b0;
            end
            md_t <= md_t_next;
            mr_t <= mr_t_next;
            rs_t <= rs_t_next;
        end
    end

    assign multiplierReg   = mr;
    assign multiplierReg_t = mr_t;
    assign product         = rs;
    assign product_t       = rs_t;

endmodule

// File: doc/multiplier_datapath_taint_word.md
Name: multiplier_datapath_taint_word

Overview:
Datapath for the sequential shift-add multiplier with word-level taint tracking. Sits directly downstream of the multiplier control FSM, which sequences it through INIT, SHIFT, LOAD/NOP and FINAL.
- Consumes the control strobes and their taint bits.
- Returns the multiplier register and its taint to the FSM for bit selection.
- Presents the 2*WIDTH product and its taint to the consumer.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
multiplicandIn  input  WIDTH  operand A.
multiplicandIn_t  input  1  taint of operand A.
multiplierIn  input  WIDTH  operand B.
multiplierIn_t  input  1  taint of operand B.
mdld / mdld_t  input  1 / 1  load multiplicand register; taint of that strobe.
mrld / mrld_t  input  1 / 1  load multiplier register; taint.
rsclear / rsclear_t  input  1 / 1  clear result register and carry; taint.
rsload / rsload_t  input  1 / 1  add multiplicand into upper result half; taint.
rsshr / rsshr_t  input  1 / 1  shift result right by one; taint.
multiplierReg  output  WIDTH  multiplier register contents (to control).
multiplierReg_t  output  1  taint of multiplierReg.
product  output  2*WIDTH  result register contents.
product_t  output  1  taint of product.

Behaviour:
- Registers: md[WIDTH-1:0], mr[WIDTH-1:0], rs[2W-1:0], carry (1 bit), and taint bits md_t, mr_t, rs_t. multiplierReg=mr, product=rs, multiplierReg_t=mr_t, product_t=rs_t. All outputs are registered, with no combinational path from inputs.
- Reset (rst=1 at posedge): every register and every taint bit goes to 0. Reset overrides all strobes in the same cycle.
- Multiplicand register: mdld=1 gives md<=multiplicandIn. Otherwise md holds.
- Multiplier register: mrld=1 gives mr<=multiplierIn. Otherwise mr holds. mr never shifts; control indexes it by bit counter.
- Result register, priority rsclear > rsload > rsshr (control keeps these one-hot):
  - rsclear: rs<=0, carry<=0.
  - rsload: {carry, rs[2W-1:W]} <= rs[2W-1:W] + md, computed in WIDTH+1 bits; rs[W-1:0] holds.
  - rsshr: rs<={carry, rs[2W-1:1]}, carry<=0.
  - None asserted: rs and carry hold.
- Net algorithm: clear, then for each multiplier bit i (LSB first) one shift, an optional add, and a final shift. The first shift acts on a cleared register (no-op). After FINAL, product = A*B exactly, with no overflow for any WIDTH-bit operands.
- Latency: product is valid on the cycle after the FINAL-state shift strobe, i.e. coincident with productDone falling.
- Taint rules (one-cycle, registered):
  - md_t_next = (mdld ? multiplicandIn_t : md_t) | mdld_t.
  - mr_t_next = (mrld ? multiplierIn_t : mr_t) | mrld_t.
  - rs_t_next = (rsclear ? 0 : rs_t) | (rsclear_t & rs_t) | rsclear_t | rsload_t | rsshr_t | ((rsload | rsload_t) & md_t).
  - A tainted strobe taints its destination whether or not the strobe is asserted.
  - Taint is sticky until cleared: only an untainted rsclear or load with untainted data drops it.
- Boundary conditions:
  - Simultaneous mdld and rsload: the add uses the old md; the new md is visible next cycle. The taint rule likewise uses the old md_t.
  - Multiple rs strobes in one cycle: data follows priority; taint ORs all contributions.
  - rst mid-multiply: everything zeroes, including taints. No partial state survives.
  - Add carry out of bit 2W-1 cannot occur, because carry is always consumed by the next shift.

Test Plan:
- WIDTH=4, A=13, B=11, all taints 0, drive the full control strobe sequence (clear/load, then shift, load, shift, load, shift, shift, load, final shift) -> product=143 (0x8F), product_t=0, multiplierReg=11.
- A=15, B=15 (max operands, every bit loads, carry path exercised) -> product=225 (0xE1); A=0, B=9 -> product=0.
- multiplicandIn_t=1 with A=6, B=0 (no rsload ever) -> md_t=1, product=0, product_t=0. Same with B=1 -> product_t=1 after the first rsload.
- Untainted data with rsload_t=1 pulsed while rsload=0 (NOP cycle) -> product_t=1 next cycle, rs value unchanged. A subsequent untainted rsclear -> product_t=0.
- rst asserted mid-multiply (after 2 shifts, with rs_t=1) -> next cycle all outputs and taints are 0. A fresh 3*5 run -> product=15.
- mdld and rsload in the same cycle (md old=2, new=7, rs upper=0) -> rs upper=2 next cycle, md=7.
